// File: rtl/dkong3_video_pkg.sv
// Shared timing defaults and helpers for the DK3 video timing block.
// Counter widths cover any legal total up to 512.
package dkong3_video_pkg;

    localparam int H_TOTAL_DEF  = 384;
    localparam int H_ACTIVE_DEF = 256;
    localparam int HS_START_DEF = 288;
    localparam int HS_END_DEF   = 320;
    localparam int V_TOTAL_DEF  = 264;
    localparam int VB_END_DEF   = 16;
    localparam int VB_START_DEF = 240;
    localparam int VS_START_DEF = 244;
    localparam int VS_END_DEF   = 248;

    localparam int H_W = 9;
    localparam int V_W = 9;

    // Half-open range test [lo, hi) done in 32-bit so a bound of 512 still fits.
    function automatic logic in_range(input int v, input int lo, input int hi);
        return (v >= lo) && (v < hi);
    endfunction

endpackage

// File: rtl/dkong3_mod_counter.sv
// Modulo-N up counter with terminal-count flag and next-value output.
// The next value lets the parent register decode that lines up with the count.
module dkong3_mod_counter #(
    parameter int MODULUS = 384,
    parameter int WIDTH   = 9
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             I_EN,
    output logic [WIDTH-1:0] O_CNT,
    output logic [WIDTH-1:0] O_NXT,
    output logic             O_TC
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    assign O_TC = (cnt_q == WIDTH'(MODULUS - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (I_EN) begin
            cnt_d = O_TC ? '0 : cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign O_CNT = cnt_q;
    assign O_NXT = cnt_d;

endmodule

// File: rtl/dkong3_hv_timing.sv
// DK3 video timing: H/V counters, registered blank/sync decode, line/frame
// strobes and the VBLANK NMI latch.
module dkong3_hv_timing
    import dkong3_video_pkg::*;
#(
    parameter int H_TOTAL  = H_TOTAL_DEF,
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int HS_START = HS_START_DEF,
    parameter int HS_END   = HS_END_DEF,
    parameter int V_TOTAL  = V_TOTAL_DEF,
    parameter int VB_END   = VB_END_DEF,
    parameter int VB_START = VB_START_DEF,
    parameter int VS_START = VS_START_DEF,
    parameter int VS_END   = VS_END_DEF
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           I_CEN,
    input  logic           I_FLIP,
    input  logic           I_NMI_EN,
    output logic [H_W-1:0] O_H_CNT,
    output logic [V_W-1:0] O_V_CNT,
    output logic [7:0]     O_HF,
    output logic [7:0]     O_VF,
    output logic [2:0]     O_H_PHASE,
    output logic           O_HBLANK,
    output logic           O_VBLANK,
    output logic           O_HSYNC,
    output logic           O_VSYNC,
    output logic           O_LINE_STB,
    output logic           O_FRAME_STB,
    output logic           O_NMI
);

    if (!(H_ACTIVE < HS_START && HS_START < HS_END && HS_END <= H_TOTAL &&
          H_TOTAL <= 512 && VB_END < VB_START && VB_START < VS_START &&
          VS_START < VS_END && VS_END <= V_TOTAL && V_TOTAL <= 512)) begin : g_bad_timing
        $error("dkong3_hv_timing: illegal timing parameter ordering");
    end

    logic [H_W-1:0] h_cnt, h_nxt;
    logic [V_W-1:0] v_cnt, v_nxt;
    logic           h_tc, v_tc, v_en, nmi_set;

    logic hblank_q, vblank_q, hsync_q, vsync_q;
    logic line_stb_q, frame_stb_q, nmi_q;

    assign v_en = I_CEN & h_tc;

    dkong3_mod_counter #(.MODULUS(H_TOTAL), .WIDTH(H_W)) u_h_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .I_EN  (I_CEN),
        .O_CNT (h_cnt),
        .O_NXT (h_nxt),
        .O_TC  (h_tc)
    );

    dkong3_mod_counter #(.MODULUS(V_TOTAL), .WIDTH(V_W)) u_v_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .I_EN  (v_en),
        .O_CNT (v_cnt),
        .O_NXT (v_nxt),
        .O_TC  (v_tc)
    );

    // Rising edge of VBLANK is exactly the line step that loads VB_START.
    assign nmi_set = v_en && (int'(v_nxt) == VB_START);

    // Flags decode the next count so they change on the same edge as the count.
    always_ff @(posedge CLK) begin
        if (RST) begin
            hblank_q    <= 1'b0;
            vblank_q    <= 1'b1;
            hsync_q     <= 1'b0;
            vsync_q     <= 1'b0;
            line_stb_q  <= 1'b0;
            frame_stb_q <= 1'b0;
            nmi_q       <= 1'b0;
        end else begin
            hblank_q    <= in_range(int'(h_nxt), H_ACTIVE, H_TOTAL);
            hsync_q     <= in_range(int'(h_nxt), HS_START, HS_END);
            vblank_q    <= !in_range(int'(v_nxt), VB_END, VB_START);
            vsync_q     <= in_range(int'(v_nxt), VS_START, VS_END);
            line_stb_q  <= v_en;
            frame_stb_q <= v_en & v_tc;
            if (!I_NMI_EN) begin
                nmi_q <= 1'b0;
            end else if (nmi_set) begin
                nmi_q <= 1'b1;
            end
        end
    end

    assign O_H_CNT     = h_cnt;
    assign O_V_CNT     = v_cnt;
    assign O_HF        = h_cnt[7:0] ^ {8{I_FLIP}};
    assign O_VF        = v_cnt[7:0] ^ {8{I_FLIP}};
    assign O_H_PHASE   = h_cnt[2:0];
    assign O_HBLANK    = hblank_q;
    assign O_VBLANK    = vblank_q;
    assign O_HSYNC     = hsync_q;
    assign O_VSYNC     = vsync_q;
    assign O_LINE_STB  = line_stb_q;
    assign O_FRAME_STB = frame_stb_q;
    assign O_NMI       = nmi_q;

endmodule

// File: tb/tb_dkong3_hv_timing.sv
// Bench for dkong3_hv_timing: a default-timing instance plus a shrunken-timing
// instance (so whole frames fit), both compared every cycle to a tick-count model.
module tb_dkong3_hv_timing;

    localparam int HT[2]  = '{384, 24};
    localparam int HA[2]  = '{256, 16};
    localparam int HSS[2] = '{288, 18};
    localparam int HSE[2] = '{320, 20};
    localparam int VT[2]  = '{264, 20};
    localparam int VBE[2] = '{16, 2};
    localparam int VBS[2] = '{240, 14};
    localparam int VSS[2] = '{244, 15};
    localparam int VSE[2] = '{248, 17};

    logic       clk, rst, cen, flip, nmi_en;
    logic [8:0] h_cnt[2], v_cnt[2];
    logic [7:0] hf[2], vf[2];
    logic [2:0] phase[2];
    logic       hblank[2], vblank[2], hsync[2], vsync[2];
    logic       line_stb[2], frame_stb[2], nmi[2];

    int n_chk  = 0;
    int n_pass = 0;

    // Model state: enabled edges since reset, modulo one frame.
    int mt[2]    = '{0, 0};
    bit mline[2] = '{0, 0};
    bit mframe[2] = '{0, 0};
    bit mnmi[2]  = '{0, 0};

    dkong3_hv_timing u_dut_def (
        .CLK(clk), .RST(rst), .I_CEN(cen), .I_FLIP(flip), .I_NMI_EN(nmi_en),
        .O_H_CNT(h_cnt[0]), .O_V_CNT(v_cnt[0]), .O_HF(hf[0]), .O_VF(vf[0]),
        .O_H_PHASE(phase[0]), .O_HBLANK(hblank[0]), .O_VBLANK(vblank[0]),
        .O_HSYNC(hsync[0]), .O_VSYNC(vsync[0]), .O_LINE_STB(line_stb[0]),
        .O_FRAME_STB(frame_stb[0]), .O_NMI(nmi[0])
    );

    dkong3_hv_timing #(
        .H_TOTAL(24), .H_ACTIVE(16), .HS_START(18), .HS_END(20),
        .V_TOTAL(20), .VB_END(2), .VB_START(14), .VS_START(15), .VS_END(17)
    ) u_dut_small (
        .CLK(clk), .RST(rst), .I_CEN(cen), .I_FLIP(flip), .I_NMI_EN(nmi_en),
        .O_H_CNT(h_cnt[1]), .O_V_CNT(v_cnt[1]), .O_HF(hf[1]), .O_VF(vf[1]),
        .O_H_PHASE(phase[1]), .O_HBLANK(hblank[1]), .O_VBLANK(vblank[1]),
        .O_HSYNC(hsync[1]), .O_VSYNC(vsync[1]), .O_LINE_STB(line_stb[1]),
        .O_FRAME_STB(frame_stb[1]), .O_NMI(nmi[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
    endtask

    task automatic model_edge(input bit rst_v, input bit cen_v, input bit nmi_v);
        for (int k = 0; k < 2; k++) begin
            bit set_v;
            set_v = 1'b0;
            if (rst_v) begin
                mt[k] = 0; mline[k] = 0; mframe[k] = 0; mnmi[k] = 0;
            end else begin
                if (cen_v) begin
                    mt[k]     = (mt[k] + 1) % (HT[k] * VT[k]);
                    mline[k]  = (mt[k] % HT[k]) == 0;
                    mframe[k] = (mt[k] == 0);
                    set_v     = (mt[k] == VBS[k] * HT[k]);
                end else begin
                    mline[k]  = 0;
                    mframe[k] = 0;
                end
                if (!nmi_v) mnmi[k] = 0;
                else if (set_v) mnmi[k] = 1;
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            int eh = mt[k] % HT[k];
            int ev = mt[k] / HT[k];
            int fm = flip ? 255 : 0;
            check($sformatf("h_cnt[%0d]", k), int'(h_cnt[k]), eh);
            check($sformatf("v_cnt[%0d]", k), int'(v_cnt[k]), ev);
            check($sformatf("hf[%0d]", k), int'(hf[k]), (eh % 256) ^ fm);
            check($sformatf("vf[%0d]", k), int'(vf[k]), (ev % 256) ^ fm);
            check($sformatf("phase[%0d]", k), int'(phase[k]), eh % 8);
            check($sformatf("hblank[%0d]", k), int'(hblank[k]), int'(eh >= HA[k]));
            check($sformatf("hsync[%0d]", k), int'(hsync[k]), int'(eh >= HSS[k] && eh < HSE[k]));
            check($sformatf("vblank[%0d]", k), int'(vblank[k]), int'(ev < VBE[k] || ev >= VBS[k]));
            check($sformatf("vsync[%0d]", k), int'(vsync[k]), int'(ev >= VSS[k] && ev < VSE[k]));
            check($sformatf("line_stb[%0d]", k), int'(line_stb[k]), int'(mline[k]));
            check($sformatf("frame_stb[%0d]", k), int'(frame_stb[k]), int'(mframe[k]));
            check($sformatf("nmi[%0d]", k), int'(nmi[k]), int'(mnmi[k]));
        end
    endtask

    task automatic step(input bit rst_v, input bit cen_v);
        rst = rst_v;
        cen = cen_v;
        @(posedge clk);
        model_edge(rst_v, cen_v, nmi_en);
        #1;
        check_all();
    endtask

    task automatic random_run(input int n);
        for (int i = 0; i < n; i++) begin
            flip = 1'($urandom_range(0, 1));
            if (nmi_en && $urandom_range(0, 399) == 0) nmi_en = 1'b0;
            else if (!nmi_en && $urandom_range(0, 99) == 0) nmi_en = 1'b1;
            step($urandom_range(0, 1499) == 0, $urandom_range(0, 3) != 0);
        end
    endtask

    initial begin
        bit found;
        rst = 1'b1; cen = 1'b0; flip = 1'b0; nmi_en = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        step(1'b1, 1'b1);

        // One full default line with continuous enable: H wraps, V -> 1.
        for (int i = 0; i < 384; i++) step(1'b0, 1'b1);
        check("v_after_line", int'(v_cnt[0]), 1);

        // Enable every 4th clock for a full line.
        for (int i = 0; i < 4 * 384; i++) step(1'b0, (i % 4) == 3);

        random_run(4000);

        // Mid-line reset on the default instance with flip set.
        nmi_en = 1'b1;
        flip   = 1'b1;
        found  = 1'b0;
        for (int i = 0; i < 1000 && !found; i++) begin
            if (mt[0] % 384 == 100) found = 1'b1;
            else step(1'b0, 1'b1);
        end
        check("wait_h100", int'(found), 1);
        step(1'b1, 1'b1);
        check("rst_hf", int'(hf[0]), 255);
        check("rst_vf", int'(vf[0]), 255);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);

        random_run(2500);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dkong3_hv_timing.md
Name: dkong3_hv_timing

Overview:
- Video timing generator for the DK3 core.
- Runs the horizontal and vertical pixel counters and decodes blank, sync and strobe signals from them.
- Produces the 3-bit H phase that drives the 3-to-8 and 2-to-4 decoders and the JK flip-flop clock enables.
- Holds the VBLANK NMI latch consumed by the CPU block.

Parameters:
- H_TOTAL, 384, pixels per line; H counter wraps at H_TOTAL-1.
- H_ACTIVE, 256, first H count of horizontal blank (blank = H >= H_ACTIVE).
- HS_START, 288, first H count with HSYNC asserted.
- HS_END, 320, first H count after HSYNC.
- V_TOTAL, 264, lines per frame.
- VB_END, 16, first visible line.
- VB_START, 240, first blanked line.
- VS_START, 244, first line with VSYNC asserted.
- VS_END, 248, first line after VSYNC.

Ports:
- CLK  in  1  core clock
- RST  in  1  synchronous reset, active-high
- I_CEN  in  1  pixel clock enable (6 MHz strobe)
- I_FLIP  in  1  screen flip select
- I_NMI_EN  in  1  NMI mask; low clears and holds the NMI latch
- O_H_CNT  out  9  horizontal count 0..H_TOTAL-1
- O_V_CNT  out  9  vertical count 0..V_TOTAL-1
- O_HF  out  8  O_H_CNT[7:0] XOR {8{I_FLIP}}
- O_VF  out  8  O_V_CNT[7:0] XOR {8{I_FLIP}}
- O_H_PHASE  out  3  O_H_CNT[2:0], decoder select
- O_HBLANK  out  1  horizontal blank
- O_VBLANK  out  1  vertical blank
- O_HSYNC  out  1  horizontal sync, active-high
- O_VSYNC  out  1  vertical sync, active-high
- O_LINE_STB  out  1  one-CLK pulse when H wraps
- O_FRAME_STB  out  1  one-CLK pulse when V wraps
- O_NMI  out  1  VBLANK NMI request, level

Behaviour:
- Clocking and reset: single clock CLK. RST is synchronous and active-high, and takes priority over I_CEN.
- Reset values:
  - H=0, V=0, HBLANK=0, VBLANK=1, HSYNC=0, VSYNC=0.
  - LINE_STB=0, FRAME_STB=0, NMI=0.
- Counter advance: all state advances only on CLK edges with I_CEN=1. With I_CEN=0 everything holds, except the strobes, which clear.
- H counter: H <= (H==H_TOTAL-1) ? 0 : H+1.
- V counter: V advances only on the cycle H wraps. V <= (V==V_TOTAL-1) ? 0 : V+1.
- Registered decode: flags are computed from the next count value, so every flag is registered and aligned with the O_H_CNT/O_V_CNT value it describes. Latency from count to flag is zero cycles.
- Flag ranges (half-open):
  - HBLANK = H in [H_ACTIVE, H_TOTAL-1].
  - HSYNC = H in [HS_START, HS_END).
  - VBLANK = V < VB_END or V >= VB_START.
  - VSYNC = V in [VS_START, VS_END).
- LINE_STB: high for exactly one CLK after the edge that loads H=0.
- FRAME_STB: high for exactly one CLK after the edge that loads H=0 and V=0.
- Back-to-back I_CEN: strobes stay one CLK wide even when I_CEN is held high continuously.
- NMI latch (JK style):
  - Set on the edge where VBLANK goes 0->1 (V loads VB_START) while I_NMI_EN=1.
  - Cleared synchronously whenever I_NMI_EN=0.
  - Holds otherwise; if set and clear occur together, clear wins.
- Flip: O_HF and O_VF are combinational XOR of registered counts with I_FLIP. There is no flip inside the counters.
- Mid-frame reset: RST asserted at any count returns all outputs to reset values on the next CLK. Counting resumes from H=0, V=0 on the first enabled edge after RST deasserts.
- Width and legality:
  - Counts never exceed TOTAL-1.
  - Required parameter ordering: H_ACTIVE < HS_START < HS_END <= H_TOTAL <= 512, and VB_END < VB_START < VS_START < VS_END <= V_TOTAL <= 512.
  - Violations are caught by an elaboration-time check.

Decomposition:
- Package dkong3_video_pkg: default timing constants (384/256/288/320/264/16/240/244/248) and count widths (H_W=9, V_W=9).
- One sub-module, dkong3_mod_counter:
  - Parameters: modulus and width.
  - Inputs: CLK, RST, enable.
  - Outputs: count and terminal-count.
  - Instantiated twice, H and V; V's enable is I_CEN AND H terminal-count.
- Decode, strobes and the NMI latch live in the top module.

Test Plan:
- Reset then 384 enabled cycles -> H runs 0..383 and returns to 0. LINE_STB pulses once, one CLK wide, the cycle H=0. V=1.
- I_CEN=1 every 4th CLK for one line -> counts change only on enabled edges. Each strobe is exactly one CLK wide. Flags do not change on disabled edges.
- Scan H=255->256, 287->288, 319->320 -> HBLANK rises at 256, HSYNC high for H 288..319 only (32 pixels). HBLANK falls at H=0.
- Full frame of 384*264 enabled cycles -> VBLANK low for V 16..239, VSYNC high V 244..247. FRAME_STB pulses once, at V=0, H=0.
- I_NMI_EN=1, run to V=240 -> O_NMI=1 from that edge. Drop I_NMI_EN at V=250 -> O_NMI=0 next CLK and stays 0 through V=240 of the next frame while enable stays low.
- Assert RST at H=100, V=120 with I_FLIP=1 -> next CLK: H=0, V=0, VBLANK=1, NMI=0, O_HF=0xFF, O_VF=0xFF.
